pattern_stimulus_sequencer: RTL and testbench

//  Drive side of the pattern-merge netlist test harness: generates LFSR stimulus

---
 rtl/pattern_stimulus_sequencer.sv | 119 +++++++++++
 tb/tb_pattern_stimulus_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_stimulus_sequencer.sv
// Stimulus/response sequencer for the pattern-merge netlist harness: drives LFSR
// vectors onto the DUT input bus and folds the delayed response bus into a MISR.
module pattern_stimulus_sequencer #(
   parameter int              IN_W      = 15,
   parameter int              OUT_W     = 13,
   parameter int              CNT_W     = 16,
   parameter int              RESP_LAT  = 1,
   parameter logic [IN_W-1:0] LFSR_TAPS = 15'h6000,
   parameter logic [OUT_W-1:0] MISR_POLY = 13'h001B
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic [IN_W-1:0]  seed,
   output logic [IN_W-1:0]  vec_out,
   output logic             vec_valid,
   input  logic [OUT_W-1:0] resp_in,
   output logic [OUT_W-1:0] signature,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int DLY_W = (RESP_LAT == 0) ? 1 : RESP_LAT;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] num_reg;
   logic [DLY_W-1:0] valid_dly;
   logic [OUT_W-1:0] sig;
   logic [IN_W-1:0]  seed_eff;
   logic [IN_W-1:0]  lfsr_next;
   logic             abort_now;
   logic             last_vec;
   logic             cap_en;
   logic             drain_pending;

   assign abort_now = abort && ((state == RUN) || (state == DRAIN));
   assign last_vec  = (count == (num_reg - CNT_W'(1)));
   assign seed_eff  = (seed == '0) ? IN_W'(1) : seed;
   assign lfsr_next = {vec_out[IN_W-2:0], ^(vec_out & LFSR_TAPS)};

   // The oldest delay-line slot is the capture enable; anything younger still pending keeps DRAIN alive.
   assign cap_en        = (RESP_LAT == 0) ? vec_valid : valid_dly[DLY_W-1];
   assign drain_pending = |(valid_dly & ~(DLY_W'(1) << (DLY_W - 1)));

   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);
   assign signature = sig;

   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_next = (num_vectors != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (last_vec) begin
               state_next = (RESP_LAT == 0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (!drain_pending) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // vec_out doubles as the LFSR register, so the first vector is already on the bus in the first RUN cycle.
   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         vec_out   <= '0;
         vec_valid <= 1'b0;
         count     <= '0;
         num_reg   <= '0;
         valid_dly <= '0;
         sig       <= '0;
      end else begin
         if (state_next == RUN) begin
            vec_valid <= 1'b1;
            vec_out   <= (state == IDLE) ? seed_eff : lfsr_next;
         end else begin
            vec_valid <= 1'b0;
            vec_out   <= '0;
         end

         count     <= (state == RUN) ? (count + CNT_W'(1)) : '0;
         valid_dly <= abort_now ? '0 : ((valid_dly << 1) | DLY_W'(vec_valid));

         if ((state == IDLE) && start && !abort) begin
            num_reg <= num_vectors;
            sig     <= '0;
         end else if (cap_en && !abort_now) begin
            sig <= {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : '0) ^ resp_in;
         end
      end
   end

endmodule

// File: tb/tb_pattern_stimulus_sequencer.sv
// Bench for pattern_stimulus_sequencer: three instances (response latency 0, 1, 3)
// share stimulus and are compared cycle by cycle against a list-based run model.
module tb_pattern_stimulus_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] num_vectors;
   logic [14:0] seed;

   logic [14:0] vec_out_l0, vec_out_l1, vec_out_l3;
   logic        vec_valid_l0, vec_valid_l1, vec_valid_l3;
   logic [12:0] sig_l0, sig_l1, sig_l3;
   logic        busy_l0, busy_l1, busy_l3;
   logic        done_l0, done_l1, done_l3;
   logic [12:0] resp_l0, resp_l1, resp_l3a, resp_l3b, resp_l3;

   bit          resp_mode;
   logic [12:0] resp_key;

   int check_count = 0;
   int pass_count  = 0;

   logic [14:0] exp_vec[$];
   logic [12:0] exp_sig[$];
   logic [14:0] obs_vec[64];
   logic [12:0] obs_sig[64];
   logic        obs_done[64];

   pattern_stimulus_sequencer #(.RESP_LAT(0)) dut_l0 (
      .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort),
      .num_vectors(num_vectors), .seed(seed), .vec_out(vec_out_l0), .vec_valid(vec_valid_l0),
      .resp_in(resp_l0), .signature(sig_l0), .busy(busy_l0), .done(done_l0));

   pattern_stimulus_sequencer #(.RESP_LAT(1)) dut_l1 (
      .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort),
      .num_vectors(num_vectors), .seed(seed), .vec_out(vec_out_l1), .vec_valid(vec_valid_l1),
      .resp_in(resp_l1), .signature(sig_l1), .busy(busy_l1), .done(done_l1));

   pattern_stimulus_sequencer #(.RESP_LAT(3)) dut_l3 (
      .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort),
      .num_vectors(num_vectors), .seed(seed), .vec_out(vec_out_l3), .vec_valid(vec_valid_l3),
      .resp_in(resp_l3), .signature(sig_l3), .busy(busy_l3), .done(done_l3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the pattern-merge netlist: a fixed function of the vector, delayed per instance
   function automatic logic [12:0] respOf(input logic [14:0] vec, input bit mode, input logic [12:0] key);
      logic [14:0] m;
      m = vec ^ (vec >> 2);
      return mode ? key : (m[12:0] + key);
   endfunction

   assign resp_l0 = respOf(vec_out_l0, resp_mode, resp_key);

   always @(posedge clk) begin
      resp_l1  <= respOf(vec_out_l1, resp_mode, resp_key);
      resp_l3a <= respOf(vec_out_l3, resp_mode, resp_key);
      resp_l3b <= resp_l3a;
      resp_l3  <= resp_l3b;
   end

   function automatic logic [14:0] lfsrNext(input logic [14:0] v);
      logic [15:0] t;
      logic        fb;
      t  = {v, 1'b0};
      fb = ($countones(v & 15'h6000) % 2) == 1;
      return t[14:0] | 15'(fb);
   endfunction

   // Multiply by x modulo x^13+x^4+x^3+x+1, then add the response word
   function automatic logic [12:0] misrStep(input logic [12:0] s, input logic [12:0] r);
      logic [13:0] t;
      t = {s, 1'b0};
      if (t[13]) t = t ^ 14'h201B;
      return t[12:0] ^ r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // stop_kind: 0 = run in progress, 1 = after abort, 2 = after reset
   task automatic checkDut(input string name, input int k, input int lat, input int n, input int stop_kind,
                           input logic [14:0] vo, input logic vv, input logic [12:0] sg,
                           input logic bz, input logic dn);
      int dk;
      int ncap;
      dk   = (n == 0) ? 0 : n + lat;
      ncap = k - lat;
      if (ncap < 0) ncap = 0;
      if (ncap > n) ncap = n;
      if (stop_kind != 0) begin
         checkOutput($sformatf("%s k%0d vec_valid", name, k), 32'(vv), 32'd0);
         checkOutput($sformatf("%s k%0d vec_out", name, k), 32'(vo), 32'd0);
         checkOutput($sformatf("%s k%0d busy", name, k), 32'(bz), 32'd0);
         checkOutput($sformatf("%s k%0d done", name, k), 32'(dn), 32'd0);
         if (stop_kind == 2) checkOutput($sformatf("%s k%0d signature", name, k), 32'(sg), 32'd0);
      end else begin
         checkOutput($sformatf("%s k%0d vec_valid", name, k), 32'(vv), 32'(k < n));
         checkOutput($sformatf("%s k%0d vec_out", name, k), 32'(vo), (k < n) ? 32'(exp_vec[k]) : 32'd0);
         checkOutput($sformatf("%s k%0d busy", name, k), 32'(bz), 32'(k < dk));
         checkOutput($sformatf("%s k%0d done", name, k), 32'(dn), 32'(k == dk));
         checkOutput($sformatf("%s k%0d signature", name, k), 32'(sg), 32'(exp_sig[ncap]));
      end
   endtask

   // Called #1 after a clock edge; k counts observation points after the start edge (k=0 first)
   task automatic applyStimulus(input logic [14:0] s, input int n, input bit mode, input logic [12:0] key,
                                input int abort_at, input int reset_at);
      logic [14:0] v;
      logic [12:0] acc;
      int          stop_kind;
      exp_vec.delete();
      exp_sig.delete();
      v   = (s == 0) ? 15'd1 : s;
      acc = '0;
      exp_sig.push_back(acc);
      for (int i = 0; i < n; i++) begin
         exp_vec.push_back(v);
         acc = misrStep(acc, respOf(v, mode, key));
         exp_sig.push_back(acc);
         v = lfsrNext(v);
      end
      resp_mode   = mode;
      resp_key    = key;
      seed        = s;
      num_vectors = 16'(n);
      start       = 1'b1;
      for (int k = 0; k <= n + 6; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         abort = 1'b0;
         rst   = 1'b0;
         if (k == 0) begin
            seed        = 15'($urandom);
            num_vectors = 16'($urandom);
         end
         stop_kind = 0;
         if (abort_at >= 0 && k > abort_at) stop_kind = 1;
         if (reset_at >= 0 && k > reset_at) stop_kind = 2;
         checkDut("lat0", k, 0, n, stop_kind, vec_out_l0, vec_valid_l0, sig_l0, busy_l0, done_l0);
         checkDut("lat1", k, 1, n, stop_kind, vec_out_l1, vec_valid_l1, sig_l1, busy_l1, done_l1);
         checkDut("lat3", k, 3, n, stop_kind, vec_out_l3, vec_valid_l3, sig_l3, busy_l3, done_l3);
         obs_vec[k]  = vec_out_l1;
         obs_sig[k]  = sig_l1;
         obs_done[k] = done_l1;
         if (k == 1 && n >= 1) start = 1'b1;
         if (k == abort_at) abort = 1'b1;
         if (k == reset_at) rst = 1'b1;
      end
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      num_vectors = '0;
      seed        = '0;
      resp_mode   = 1'b0;
      resp_key    = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset vec_valid", 32'({vec_valid_l0, vec_valid_l1, vec_valid_l3}), 32'd0);
      checkOutput("reset vec_out", 32'(vec_out_l0 | vec_out_l1 | vec_out_l3), 32'd0);
      checkOutput("reset signature", 32'(sig_l0 | sig_l1 | sig_l3), 32'd0);
      checkOutput("reset busy", 32'({busy_l0, busy_l1, busy_l3}), 32'd0);
      checkOutput("reset done", 32'({done_l0, done_l1, done_l3}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] basic run: seed 1, three vectors, zero response");
      applyStimulus(15'h0001, 3, 1'b1, 13'h0000, -1, -1);
      checkOutput("t1 vec0", 32'(obs_vec[0]), 32'h0001);
      checkOutput("t1 vec1", 32'(obs_vec[1]), 32'h0002);
      checkOutput("t1 vec2", 32'(obs_vec[2]), 32'h0004);
      checkOutput("t1 done timing", 32'(obs_done[4]), 32'd1);
      checkOutput("t1 signature", 32'(obs_sig[4]), 32'h0000);

      $display("[TB] constant response 1, two vectors");
      applyStimulus(15'h1234, 2, 1'b1, 13'h0001, -1, -1);
      checkOutput("t2 sig first capture", 32'(obs_sig[2]), 32'h0001);
      checkOutput("t2 sig final", 32'(obs_sig[3]), 32'h0003);

      $display("[TB] zero seed and empty run");
      applyStimulus(15'h0000, 4, 1'b0, 13'(($urandom)), -1, -1);
      checkOutput("t3 zero seed vec0", 32'(obs_vec[0]), 32'h0001);
      applyStimulus(15'($urandom), 0, 1'b0, 13'($urandom), -1, -1);
      checkOutput("t3 empty run done", 32'(obs_done[0]), 32'd1);

      $display("[TB] abort in second RUN cycle, then clean restart");
      applyStimulus(15'($urandom), 10, 1'b0, 13'($urandom), 1, -1);
      applyStimulus(15'($urandom), 7, 1'b0, 13'($urandom), -1, -1);

      $display("[TB] reset during DRAIN");
      applyStimulus(15'($urandom), 5, 1'b0, 13'($urandom), -1, 5);

      $display("[TB] randomized runs");
      for (int r = 0; r < 8; r++) begin
         applyStimulus(15'($urandom), int'($urandom_range(1, 24)), bit'($urandom_range(0, 1)),
                       13'($urandom), -1, -1);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
